sccomp_dbg_ctrl: RTL and testbench

Synthesizable debug and run controller that sits between a host/bench and the single-cycle CPU (sccomp). It replaces hand-timed reset, run and reg_sel probing with a command-driven block that drives CPU reset and clock-enable, and supports N-instruction stepping and PC breakpoints. It also dumps the whole register file through reg_sel/reg_data with ready/valid backpressure.

---
 rtl/sccomp_dbg_pkg.sv | 33 +++
 rtl/sccomp_dbg_ctrl_if.sv | 33 +++
 rtl/sccomp_bp_match.sv | 55 +++++
 rtl/sccomp_dbg_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_sccomp_dbg_ctrl.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sccomp_dbg_pkg.sv
// Shared types for the sccomp debug/run controller.
// Command opcodes, controller states and width constants.
package sccomp_dbg_pkg;

   localparam int OP_W   = 3;
   localparam int SLOT_W = 3;
   localparam int CNT_W  = 32;

   typedef enum logic [OP_W-1:0] {
      OP_NOP   = 3'd0,
      OP_RUN   = 3'd1,
      OP_HALT  = 3'd2,
      OP_STEP  = 3'd3,
      OP_DUMP  = 3'd4,
      OP_SETBP = 3'd5,
      OP_CLRBP = 3'd6
   } cmd_op_e;

   typedef enum logic [2:0] {
      ST_RESET,
      ST_HALT,
      ST_RUN,
      ST_STEP,
      ST_DUMP_SEL,
      ST_DUMP_OUT
   } state_e;

   function automatic logic slot_ok(input logic [SLOT_W-1:0] slot,
                                    input int num_bp);
      return int'(slot) < num_bp;
   endfunction

endpackage

// File: rtl/sccomp_dbg_ctrl_if.sv
// Host-side bundle: command handshake plus register dump stream.
// master = host/bench, slave = controller.
interface sccomp_dbg_ctrl_if
   import sccomp_dbg_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SEL_W  = 5
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [OP_W-1:0]   cmd_op;
   logic [ADDR_W-1:0] cmd_arg;
   logic [SLOT_W-1:0] cmd_slot;
   logic              cmd_err;
   logic              dump_valid;
   logic              dump_ready;
   logic [SEL_W-1:0]  dump_idx;
   logic [DATA_W-1:0] dump_data;
   logic              dump_done;

   modport master (
      output cmd_valid, cmd_op, cmd_arg, cmd_slot, dump_ready,
      input  cmd_ready, cmd_err, dump_valid, dump_idx, dump_data,
             dump_done
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_arg, cmd_slot, dump_ready,
      output cmd_ready, cmd_err, dump_valid, dump_idx, dump_data,
             dump_done
   );
endinterface

// File: rtl/sccomp_bp_match.sv
// PC breakpoint slots with enable bits.
// Match is combinational so RUN can gate cpu_en in the same cycle.
module sccomp_bp_match
   import sccomp_dbg_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NUM_BP = 2
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              wr_en,
   input  logic              wr_set,
   input  logic [SLOT_W-1:0] wr_slot,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [ADDR_W-1:0] pc,
   output logic              match
);

   logic [ADDR_W-1:0] addr_q [NUM_BP];
   logic [ADDR_W-1:0] addr_d [NUM_BP];
   logic [NUM_BP-1:0] en_q;
   logic [NUM_BP-1:0] en_d;

   // Slot write: set loads address and enables, clear wipes both.
   always_comb begin
      addr_d = addr_q;
      en_d   = en_q;
      for (int i = 0; i < NUM_BP; i++) begin
         if (wr_en && wr_slot == SLOT_W'(i)) begin
            en_d[i]   = wr_set;
            addr_d[i] = wr_set ? wr_addr : '0;
         end
      end
   end

   // Any enabled slot equal to the current PC.
   always_comb begin
      match = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (en_q[i] && addr_q[i] == pc) match = 1'b1;
      end
   end

   // Slot registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         en_q <= '0;
         for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
      end else begin
         en_q   <= en_d;
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/sccomp_dbg_ctrl.sv
// Debug/run controller for sccomp: reset sequencing, run/halt,
// N-step, PC breakpoints and a backpressured register dump.
module sccomp_dbg_ctrl
   import sccomp_dbg_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SEL_W      = 5,
   parameter int NUM_BP     = 2,
   parameter int RST_CYCLES = 2,
   parameter int AUTORUN    = 0
) (
   input  logic              clk,
   input  logic              rstn,
   sccomp_dbg_ctrl_if.slave  bus,
   output logic              cpu_rstn,
   output logic              cpu_en,
   input  logic [ADDR_W-1:0] cpu_pc,
   output logic [SEL_W-1:0]  reg_sel,
   input  logic [DATA_W-1:0] reg_data,
   output logic              halted,
   output logic              bp_hit,
   output logic [CNT_W-1:0]  cycle_cnt
);

   localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [RCW-1:0]   RST_LAST = RCW'(RST_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_IDX = '1;

   state_e            state_q, state_d;
   logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
   logic [ADDR_W-1:0] step_cnt_q, step_cnt_d;
   logic              skip_q, skip_d;
   logic [SEL_W-1:0]  idx_q, idx_d;
   logic [SEL_W-1:0]  reg_sel_q, reg_sel_d;
   logic              dump_valid_q, dump_valid_d;
   logic [SEL_W-1:0]  dump_idx_q, dump_idx_d;
   logic [DATA_W-1:0] dump_data_q, dump_data_d;
   logic              dump_done_q, dump_done_d;
   logic              cmd_err_q, cmd_err_d;
   logic              bp_hit_q, bp_hit_d;
   logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
   logic              cpu_rstn_q, cpu_rstn_d;

   logic    cmd_ready;
   logic    cmd_fire;
   cmd_op_e op;
   logic    match;
   logic    bp_stop;
   logic    bp_wr;
   logic    bp_set;

   sccomp_bp_match #(
      .ADDR_W (ADDR_W),
      .NUM_BP (NUM_BP)
   ) u_bp (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (bp_wr),
      .wr_set  (bp_set),
      .wr_slot (bus.cmd_slot),
      .wr_addr (bus.cmd_arg),
      .pc      (cpu_pc),
      .match   (match)
   );

   // Run gating is combinational so a bp instruction never retires.
   always_comb begin
      cmd_ready = state_q inside {ST_HALT, ST_RUN, ST_STEP};
      cmd_fire  = bus.cmd_valid && cmd_ready;
      op        = cmd_op_e'(bus.cmd_op);
      bp_stop   = match && !skip_q;
      cpu_en    = (state_q == ST_RUN && !bp_stop) ||
                  (state_q == ST_STEP);
   end

   // Next-state and output-register logic.
   always_comb begin
      state_d      = state_q;
      rst_cnt_d    = rst_cnt_q;
      step_cnt_d   = step_cnt_q;
      skip_d       = skip_q;
      idx_d        = idx_q;
      reg_sel_d    = reg_sel_q;
      dump_valid_d = dump_valid_q;
      dump_idx_d   = dump_idx_q;
      dump_data_d  = dump_data_q;
      dump_done_d  = 1'b0;
      cmd_err_d    = 1'b0;
      bp_hit_d     = 1'b0;
      cpu_rstn_d   = cpu_rstn_q;
      cycle_cnt_d  = cycle_cnt_q + {{(CNT_W-1){1'b0}}, cpu_en};
      bp_wr        = 1'b0;
      bp_set       = 1'b0;
      unique case (state_q)
         ST_RESET: begin
            if (rst_cnt_q == RST_LAST) begin
               cpu_rstn_d = 1'b1;
               if (AUTORUN != 0) begin
                  state_d = ST_RUN;
                  skip_d  = 1'b1;
               end else begin
                  state_d = ST_HALT;
               end
            end else begin
               rst_cnt_d = rst_cnt_q + 1'b1;
            end
         end
         ST_HALT: begin
            if (cmd_fire) begin
               case (op)
                  OP_NOP, OP_HALT: ;
                  OP_RUN: begin
                     state_d = ST_RUN;
                     skip_d  = 1'b1;
                  end
                  OP_STEP: begin
                     state_d    = ST_STEP;
                     step_cnt_d = (bus.cmd_arg == '0) ?
                                  ADDR_W'(1) : bus.cmd_arg;
                  end
                  OP_DUMP: begin
                     state_d = ST_DUMP_SEL;
                     idx_d   = '0;
                  end
                  OP_SETBP, OP_CLRBP: begin
                     if (slot_ok(bus.cmd_slot, NUM_BP)) begin
                        bp_wr  = 1'b1;
                        bp_set = (op == OP_SETBP);
                     end else begin
                        cmd_err_d = 1'b1;
                     end
                  end
                  default: cmd_err_d = 1'b1;
               endcase
            end
         end
         ST_RUN: begin
            skip_d = 1'b0;
            if (bp_stop) begin
               state_d  = ST_HALT;
               bp_hit_d = 1'b1;
            end
            if (cmd_fire && op != OP_NOP) begin
               if (op == OP_HALT) state_d = ST_HALT;
               else cmd_err_d = 1'b1;
            end
         end
         ST_STEP: begin
            if (step_cnt_q == ADDR_W'(1)) state_d = ST_HALT;
            else step_cnt_d = step_cnt_q - 1'b1;
            if (cmd_fire && op != OP_NOP) begin
               if (op == OP_HALT) state_d = ST_HALT;
               else cmd_err_d = 1'b1;
            end
         end
         ST_DUMP_SEL: begin
            reg_sel_d = idx_q;
            state_d   = ST_DUMP_OUT;
         end
         ST_DUMP_OUT: begin
            if (!dump_valid_q) begin
               dump_valid_d = 1'b1;
               dump_idx_d   = reg_sel_q;
               dump_data_d  = reg_data;
            end else if (bus.dump_ready) begin
               dump_valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  dump_done_d = 1'b1;
                  state_d     = ST_HALT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ST_DUMP_SEL;
               end
            end
         end
         default: state_d = ST_RESET;
      endcase
   end

   // State and registered outputs; reset aborts any activity.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_RESET;
         rst_cnt_q    <= '0;
         step_cnt_q   <= '0;
         skip_q       <= 1'b0;
         idx_q        <= '0;
         reg_sel_q    <= '0;
         dump_valid_q <= 1'b0;
         dump_idx_q   <= '0;
         dump_data_q  <= '0;
         dump_done_q  <= 1'b0;
         cmd_err_q    <= 1'b0;
         bp_hit_q     <= 1'b0;
         cycle_cnt_q  <= '0;
         cpu_rstn_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rst_cnt_q    <= rst_cnt_d;
         step_cnt_q   <= step_cnt_d;
         skip_q       <= skip_d;
         idx_q        <= idx_d;
         reg_sel_q    <= reg_sel_d;
         dump_valid_q <= dump_valid_d;
         dump_idx_q   <= dump_idx_d;
         dump_data_q  <= dump_data_d;
         dump_done_q  <= dump_done_d;
         cmd_err_q    <= cmd_err_d;
         bp_hit_q     <= bp_hit_d;
         cycle_cnt_q  <= cycle_cnt_d;
         cpu_rstn_q   <= cpu_rstn_d;
      end
   end

   assign bus.cmd_ready  = cmd_ready;
   assign bus.cmd_err    = cmd_err_q;
   assign bus.dump_valid = dump_valid_q;
   assign bus.dump_idx   = dump_idx_q;
   assign bus.dump_data  = dump_data_q;
   assign bus.dump_done  = dump_done_q;
   assign cpu_rstn       = cpu_rstn_q;
   assign reg_sel        = reg_sel_q;
   assign halted         = (state_q == ST_HALT);
   assign bp_hit         = bp_hit_q;
   assign cycle_cnt      = cycle_cnt_q;

endmodule

// File: tb/tb_sccomp_dbg_ctrl.sv
// Directed bench for sccomp_dbg_ctrl with a toy CPU model
// (PC += 4 per enabled cycle, r[i] = i*0x11) and a dump scoreboard.
module tb_sccomp_dbg_ctrl;
   import sccomp_dbg_pkg::*;

   logic        clk;
   logic        rstn;
   logic        cpu_rstn;
   logic        cpu_en;
   logic [31:0] cpu_pc;
   logic [4:0]  reg_sel;
   logic [31:0] reg_data;
   logic        halted;
   logic        bp_hit;
   logic [31:0] cycle_cnt;

   int compared   = 0;
   int mismatched = 0;

   logic [36:0] exp_q[$];
   logic        hold_pend = 1'b0;
   logic [36:0] hold_val  = '0;

   sccomp_dbg_ctrl_if #(.ADDR_W(32), .DATA_W(32), .SEL_W(5)) bus ();

   sccomp_dbg_ctrl #(
      .ADDR_W(32), .DATA_W(32), .SEL_W(5),
      .NUM_BP(2), .RST_CYCLES(2), .AUTORUN(0)
   ) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus),
      .cpu_rstn  (cpu_rstn),
      .cpu_en    (cpu_en),
      .cpu_pc    (cpu_pc),
      .reg_sel   (reg_sel),
      .reg_data  (reg_data),
      .halted    (halted),
      .bp_hit    (bp_hit),
      .cycle_cnt (cycle_cnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Toy CPU: PC resets to 0, advances by 4 on enabled cycles.
   always @(posedge clk) begin
      if (!cpu_rstn) cpu_pc <= '0;
      else if (cpu_en) cpu_pc <= cpu_pc + 32'd4;
   end

   assign reg_data = {27'd0, reg_sel} * 32'h11;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] op, input logic [31:0] arg,
                       input logic [2:0] slot);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_arg   = arg;
      bus.cmd_slot  = slot;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 3'd0;
   endtask

   task automatic push_dump();
      for (int i = 0; i < 32; i++) begin
         logic [31:0] d;
         d = i * 32'h11;
         exp_q.push_back({5'(i), d});
      end
   endtask

   // Scoreboard side: beats accepted at the next edge are popped here,
   // and a beat stalled by ready=0 must not change.
   always @(negedge clk) begin
      if (bus.dump_valid && hold_pend)
         chk("dump_hold", {bus.dump_idx, bus.dump_data}, hold_val);
      hold_pend <= bus.dump_valid && !bus.dump_ready;
      hold_val  <= {bus.dump_idx, bus.dump_data};
      if (bus.dump_valid && bus.dump_ready) begin
         if (exp_q.size() != 0)
            chk("dump_beat", {bus.dump_idx, bus.dump_data},
                exp_q.pop_front());
         else
            chk("dump_extra", {bus.dump_idx, bus.dump_data}, 'x);
      end
   end

   initial begin
      int n;
      rstn           = 1'b0;
      bus.cmd_valid  = 1'b0;
      bus.cmd_op     = 3'd0;
      bus.cmd_arg    = '0;
      bus.cmd_slot   = '0;
      bus.dump_ready = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_cpu_rstn", cpu_rstn, 0);
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      chk("rst_halted", halted, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_dump_valid", bus.dump_valid, 0);

      // Reset sequence: cpu_rstn rises on the 2nd edge seeing rstn=1
      rstn = 1'b1;
      tick();
      chk("seq_cpu_rstn_e1", cpu_rstn, 0);
      chk("seq_halted_e1", halted, 0);
      tick();
      chk("seq_cpu_rstn_e2", cpu_rstn, 1);
      chk("seq_halted_e2", halted, 1);
      chk("seq_cpu_en", cpu_en, 0);
      chk("seq_cmd_ready", bus.cmd_ready, 1);

      // Breakpoint at 0x10
      send(OP_SETBP, 32'h10, 3'd0);
      chk("setbp_err", bus.cmd_err, 0);
      send(OP_RUN, 32'h0, 3'd0);
      for (int i = 0; i < 20; i++) begin
         if (!cpu_en) break;
         tick();
      end
      chk("bp_pc", cpu_pc, 32'h10);
      chk("bp_cpu_en", cpu_en, 0);
      tick();
      chk("bp_hit", bp_hit, 1);
      chk("bp_halted", halted, 1);
      chk("bp_cycle_cnt", cycle_cnt, 4);
      tick();
      chk("bp_hit_pulse", bp_hit, 0);

      // RUN from the bp address proceeds; STEP in RUN is illegal
      send(OP_RUN, 32'h0, 3'd0);
      chk("skip_once_en", cpu_en, 1);
      repeat (3) tick();
      send(OP_STEP, 32'd5, 3'd0);
      chk("run_step_err", bus.cmd_err, 1);
      chk("run_step_state", halted, 0);
      send(OP_HALT, 32'h0, 3'd0);
      chk("halt_halted", halted, 1);
      chk("halt_cpu_en", cpu_en, 0);
      chk("halt_err", bus.cmd_err, 0);
      chk("halt_pc", cpu_pc, 32'h24);
      chk("halt_cycle_cnt", cycle_cnt, 9);

      // STEP 3 then STEP 0
      send(OP_STEP, 32'd3, 3'd0);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         n += int'(cpu_en);
         tick();
      end
      chk("step3_cycles", n, 3);
      chk("step3_cnt", cycle_cnt, 12);
      chk("step3_halted", halted, 1);
      send(OP_STEP, 32'd0, 3'd0);
      n = 0;
      for (int i = 0; i < 4; i++) begin
         n += int'(cpu_en);
         tick();
      end
      chk("step0_cycles", n, 1);
      chk("step0_cnt", cycle_cnt, 13);

      // Bad slot is rejected; cleared slot no longer matches
      send(OP_SETBP, 32'h40, 3'd5);
      chk("slot5_err", bus.cmd_err, 1);
      chk("slot5_halted", halted, 1);
      send(OP_SETBP, 32'h48, 3'd1);
      chk("slot1_set_err", bus.cmd_err, 0);
      send(OP_CLRBP, 32'h0, 3'd1);
      chk("slot1_clr_err", bus.cmd_err, 0);
      send(OP_RUN, 32'h0, 3'd0);
      repeat (8) tick();
      chk("pass_pc", cpu_pc, 32'h54);
      chk("pass_running", halted, 0);
      send(OP_HALT, 32'h0, 3'd0);
      chk("pass_cycle_cnt", cycle_cnt, 22);

      // Full dump with ready toggling
      push_dump();
      send(OP_DUMP, 32'h0, 3'd0);
      chk("dump_lat0", bus.dump_valid, 0);
      chk("dump_cmd_ready", bus.cmd_ready, 0);
      tick();
      chk("dump_lat1", bus.dump_valid, 0);
      tick();
      chk("dump_lat2", bus.dump_valid, 1);
      chk("dump_first_idx", bus.dump_idx, 0);
      for (int i = 0; i < 400; i++) begin
         bus.dump_ready = !bus.dump_ready;
         tick();
         if (bus.dump_done) break;
      end
      bus.dump_ready = 1'b0;
      chk("dump_done", bus.dump_done, 1);
      chk("dump_halted", halted, 1);
      chk("dump_valid_end", bus.dump_valid, 0);
      chk("dump_beats_left", exp_q.size(), 0);
      tick();
      chk("dump_done_pulse", bus.dump_done, 0);

      // Reset during beat 7 aborts the dump
      push_dump();
      send(OP_DUMP, 32'h0, 3'd0);
      bus.dump_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (bus.dump_valid && bus.dump_idx == 5'd7) break;
         tick();
      end
      chk("abort_at_idx", bus.dump_idx, 7);
      bus.dump_ready = 1'b0;
      rstn = 1'b0;
      tick();
      chk("abort_valid", bus.dump_valid, 0);
      chk("abort_cpu_rstn", cpu_rstn, 0);
      chk("abort_done", bus.dump_done, 0);
      chk("abort_cycle_cnt", cycle_cnt, 0);
      chk("abort_beats_left", exp_q.size(), 25);
      exp_q.delete();
      rstn = 1'b1;
      tick();
      chk("re_cpu_rstn_e1", cpu_rstn, 0);
      chk("re_done_e1", bus.dump_done, 0);
      tick();
      chk("re_cpu_rstn_e2", cpu_rstn, 1);
      chk("re_halted", halted, 1);
      chk("re_done_e2", bus.dump_done, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
